// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART TX FIFO scheduler.
// Optional build macro: UART_SCHED_PRIO_EN (requester 0 gets strict priority).
package uart_sched_pkg;

    localparam int unsigned NREQ_DEF  = 2;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned MAX_NREQ  = 8;
    localparam int unsigned MAX_ID_W  = 3;
    localparam int unsigned LVL_W     = $clog2(DEPTH_DEF);
    localparam int unsigned ID_W      = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_SEND = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    // First asserted valid bit at or after ptr, wrapping within n requesters.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                      input logic [MAX_ID_W-1:0] ptr,
                                      input int unsigned         n);
        pick_t               p;
        int unsigned         j;
        logic [MAX_ID_W-1:0] ji;
        p = '0;
        for (int unsigned k = 0; k < MAX_NREQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= n) j = j - n;
            ji = MAX_ID_W'(j);
            if ((k < n) && !p.found && valid[ji]) begin
                p.found = 1'b1;
                p.idx   = ji;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_fifo_sched_if.sv
// Bundle of requester, FIFO, TX-core and interrupt signals around the scheduler.
// master = scheduler side, slave = producers/FIFO/TX environment.
interface uart_fifo_sched_if #(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned LVL_W = $clog2(DEPTH);
    localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]            req_valid;
    logic [NREQ*DATA_WIDTH-1:0] req_data;
    logic [NREQ-1:0]            req_ready;
    logic                       fifo_w_en;
    logic [DATA_WIDTH-1:0]      fifo_data_in;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_r_en;
    logic [DATA_WIDTH-1:0]      fifo_data_out;
    logic                       tx_start;
    logic [DATA_WIDTH-1:0]      tx_data;
    logic                       tx_busy;
    logic                       irq_clr;
    logic                       irq;
    logic [LVL_W-1:0]           level;
    logic [ID_W-1:0]            grant_id;

    modport master (
        input  req_valid, req_data, fifo_full, fifo_empty, fifo_data_out, tx_busy, irq_clr,
        output req_ready, fifo_w_en, fifo_data_in, fifo_r_en, tx_start, tx_data, irq, level, grant_id
    );

    modport slave (
        output req_valid, req_data, fifo_full, fifo_empty, fifo_data_out, tx_busy, irq_clr,
        input  req_ready, fifo_w_en, fifo_data_in, fifo_r_en, tx_start, tx_data, irq, level, grant_id
    );
endinterface

// File: rtl/uart_fifo_sched_rr_arb.sv
// Round-robin write-port arbiter: combinational pick, registered pointer.
// With UART_SCHED_PRIO_EN, requester 0 wins outright and the pointer skips 0.
module uart_rr_arb
    import uart_sched_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     i_valid,
    input  logic                i_en,
    output logic [NREQ-1:0]     o_grant,
    output logic [MAX_ID_W-1:0] o_idx,
    output logic                o_found
);
    logic [MAX_ID_W-1:0] r_rr_ptr;
    logic [MAX_NREQ-1:0] w_valid;
    logic [MAX_ID_W-1:0] w_ptr_nxt;
    pick_t               w_pick;

    // Pick the winner and the pointer that follows it.
    always_comb begin
        w_valid = MAX_NREQ'(i_valid);
`ifdef UART_SCHED_PRIO_EN
        if (i_valid[0]) begin
            w_pick.found = 1'b1;
            w_pick.idx   = '0;
        end else begin
            w_pick = rr_pick(w_valid & ~MAX_NREQ'(1), r_rr_ptr, NREQ);
        end
`else
        w_pick = rr_pick(w_valid, r_rr_ptr, NREQ);
`endif
        w_ptr_nxt = (w_pick.idx == MAX_ID_W'(NREQ - 1)) ? '0 : w_pick.idx + MAX_ID_W'(1);
`ifdef UART_SCHED_PRIO_EN
        if (w_ptr_nxt == '0) w_ptr_nxt = MAX_ID_W'(1);
`endif
    end

    assign o_found = i_en && w_pick.found;
    assign o_idx   = w_pick.idx;
    assign o_grant = o_found ? (NREQ'(1) << w_pick.idx) : '0;

    // Advance past the winner only when a transfer actually happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (o_found) begin
`ifdef UART_SCHED_PRIO_EN
            if (w_pick.idx != '0) r_rr_ptr <= w_ptr_nxt;
`else
            r_rr_ptr <= w_ptr_nxt;
`endif
        end
    end
endmodule

// File: rtl/uart_fifo_sched.sv
// UART TX FIFO scheduler: arbitrates FIFO writes, drains FIFO into the TX core,
// tracks occupancy and raises a sticky watermark irq.
// Optional build macro: UART_SCHED_PRIO_EN (see uart_rr_arb).
// fifo_data_out is expected to present the head entry; it is sampled during POP.
module uart_fifo_sched
    import uart_sched_pkg::*;
#(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IRQ_LEVEL  = 2
) (
    input logic            clk,
    input logic            rst,
    uart_fifo_sched_if.master bus
);
    localparam int unsigned LVL_WIDTH = $clog2(DEPTH);
    localparam int unsigned ID_WIDTH  = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t                r_state, w_state_nxt;
    logic [LVL_WIDTH-1:0]  r_level;
    logic                  r_irq;
    logic [ID_WIDTH-1:0]   r_grant_id;
    logic                  r_fifo_r_en;
    logic                  r_tx_start;
    logic [DATA_WIDTH-1:0] r_tx_data;

    logic                  w_wr_allow;
    logic                  w_wr;
    logic [NREQ-1:0]       w_grant;
    logic [MAX_ID_W-1:0]   w_idx;
    logic [DATA_WIDTH-1:0] w_wr_data;

    // Writes are blocked while popping, when full, or at capacity.
    assign w_wr_allow = !rst && !bus.fifo_full && (r_state != ST_POP)
                        && (r_level < LVL_WIDTH'(DEPTH - 1));

    uart_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_valid (bus.req_valid),
        .i_en    (w_wr_allow),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_found (w_wr)
    );

    // Route the granted requester's byte to the FIFO.
    always_comb begin
        w_wr_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_grant[i]) w_wr_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.req_ready    = w_grant;
    assign bus.fifo_w_en    = w_wr;
    assign bus.fifo_data_in = w_wr_data;
    assign bus.fifo_r_en    = r_fifo_r_en;
    assign bus.tx_start     = r_tx_start;
    assign bus.tx_data      = r_tx_data;
    assign bus.irq          = r_irq;
    assign bus.level        = r_level;
    assign bus.grant_id     = r_grant_id;

    // Drain FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Drain FSM next state; waits in IDLE if level and fifo_empty disagree.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if ((r_level != '0) && !bus.fifo_empty && !bus.tx_busy) w_state_nxt = ST_POP;
            ST_POP:  w_state_nxt = ST_SEND;
            ST_SEND: w_state_nxt = ST_HOLD;
            ST_HOLD: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered FIFO read enable, TX start pulse and captured TX byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_r_en <= 1'b0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            r_fifo_r_en <= (w_state_nxt == ST_POP);
            r_tx_start  <= (w_state_nxt == ST_SEND);
            if (r_state == ST_POP) r_tx_data <= bus.fifo_data_out;
        end
    end

    // Occupancy, last grant and sticky watermark irq (set beats clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level    <= '0;
            r_irq      <= 1'b0;
            r_grant_id <= '0;
        end else begin
            if (w_wr) begin
                r_level    <= r_level + LVL_WIDTH'(1);
                r_grant_id <= ID_WIDTH'(w_idx);
            end else if (r_state == ST_POP) begin
                r_level <= r_level - LVL_WIDTH'(1);
            end
            if (w_wr && ((r_level + LVL_WIDTH'(1)) == LVL_WIDTH'(IRQ_LEVEL))) r_irq <= 1'b1;
            else if (bus.irq_clr)                                            r_irq <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_fifo_sched.sv
// Directed bench for uart_fifo_sched with a behavioural 4-entry FIFO.
// Expectations follow UART_SCHED_PRIO_EN when the bench is built with it.
module tb_uart_fifo_sched;
    localparam int unsigned NREQ = 2, DEPTH = 4, DW = 8, IRQ_LEVEL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_full = 1'b0;
    always #5 clk = ~clk;

    uart_fifo_sched_if #(.NREQ(NREQ), .DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

    uart_fifo_sched #(.NREQ(NREQ), .DEPTH(DEPTH), .DATA_WIDTH(DW), .IRQ_LEVEL(IRQ_LEVEL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural FIFO, reset together with the scheduler.
    logic [DW-1:0] m_mem [DEPTH];
    logic [1:0]    m_wp, m_rp;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wp <= '0;
            m_rp <= '0;
            for (int i = 0; i < int'(DEPTH); i++) m_mem[i] <= '0;
        end else begin
            if (bus.fifo_w_en) begin
                m_mem[m_wp] <= bus.fifo_data_in;
                m_wp        <= m_wp + 2'd1;
            end
            if (bus.fifo_r_en) m_rp <= m_rp + 2'd1;
        end
    end
    assign bus.fifo_full     = ((m_wp + 2'd1) == m_rp) | force_full;
    assign bus.fifo_empty    = (m_wp == m_rp);
    assign bus.fifo_data_out = m_mem[m_rp];

    // Counts of FIFO writes and TX starts, for loss/duplication checks.
    int n_wr = 0, n_txs = 0;
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.fifo_w_en) n_wr  <= n_wr + 1;
            if (bus.tx_start)  n_txs <= n_txs + 1;
        end
    end

    int n_checks = 0, n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.tx_busy    = 1'b0;
        bus.irq_clr    = 1'b0;
        force_full     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait (bounded) for the next tx_start and check its byte.
    task automatic wait_tx(input string tag, input logic [7:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (bus.tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen) check_eq(tag, 32'(bus.tx_data), 32'(exp));
        else      check_eq({tag, "_timeout"}, 32'(0), 32'(1));
    endtask

    logic [1:0] e_g1;
    logic [7:0] e_d1;
    logic       e_gid1;
    int         base_wr, base_tx;

    initial begin
`ifdef UART_SCHED_PRIO_EN
        e_g1 = 2'b01; e_d1 = 8'h41; e_gid1 = 1'b0;
`else
        e_g1 = 2'b10; e_d1 = 8'h42; e_gid1 = 1'b1;
`endif
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_busy   = 1'b0;
        bus.irq_clr   = 1'b0;

        // Reset values, with requests pending during reset.
        @(negedge clk);
        bus.req_valid = 2'b11;
        #1;
        check_eq("rst_level",    32'(bus.level),     32'h0);
        check_eq("rst_irq",      32'(bus.irq),       32'h0);
        check_eq("rst_grant_id", 32'(bus.grant_id),  32'h0);
        check_eq("rst_tx_start", 32'(bus.tx_start),  32'h0);
        check_eq("rst_tx_data",  32'(bus.tx_data),   32'h0);
        check_eq("rst_r_en",     32'(bus.fifo_r_en), 32'h0);
        check_eq("rst_w_en",     32'(bus.fifo_w_en), 32'h0);
        check_eq("rst_ready",    32'(bus.req_ready), 32'h0);

        // 1: both requesters held valid, drain running.
        do_reset();
        bus.req_data = {8'h42, 8'h41}; bus.req_valid = 2'b11; #1;
        check_eq("t1_ready0", 32'(bus.req_ready),    32'h1);
        check_eq("t1_data0",  32'(bus.fifo_data_in), 32'h41);
        check_eq("t1_wen0",   32'(bus.fifo_w_en),    32'h1);
        @(negedge clk); #1;
        check_eq("t1_ready1", 32'(bus.req_ready),    32'(e_g1));
        check_eq("t1_data1",  32'(bus.fifo_data_in), 32'(e_d1));
        check_eq("t1_gid0",   32'(bus.grant_id),     32'h0);
        check_eq("t1_level1", 32'(bus.level),        32'h1);
        @(negedge clk); #1;
        check_eq("t1_pop_ready", 32'(bus.req_ready), 32'h0);
        check_eq("t1_pop_wen",   32'(bus.fifo_w_en), 32'h0);
        check_eq("t1_pop_ren",   32'(bus.fifo_r_en), 32'h1);
        check_eq("t1_gid1",      32'(bus.grant_id),  32'(e_gid1));
        check_eq("t1_irq",       32'(bus.irq),       32'h1);
        check_eq("t1_level2",    32'(bus.level),     32'h2);
        @(negedge clk); #1;
        check_eq("t1_send_start", 32'(bus.tx_start),     32'h1);
        check_eq("t1_send_data",  32'(bus.tx_data),      32'h41);
        check_eq("t1_ready2",     32'(bus.req_ready),    32'h1);
        check_eq("t1_data2",      32'(bus.fifo_data_in), 32'h41);
        @(negedge clk);
        bus.req_valid = '0;

        // 2: fill to capacity with TX busy, then drain in order.
        do_reset();
        bus.tx_busy = 1'b1;
        bus.req_valid = 2'b01; bus.req_data = {8'h00, 8'h31}; #1;
        check_eq("t2_ready0", 32'(bus.req_ready),    32'h1);
        check_eq("t2_data0",  32'(bus.fifo_data_in), 32'h31);
        @(negedge clk); bus.req_data = {8'h00, 8'h32}; #1;
        check_eq("t2_level1", 32'(bus.level),        32'h1);
        check_eq("t2_irq1",   32'(bus.irq),          32'h0);
        check_eq("t2_data1",  32'(bus.fifo_data_in), 32'h32);
        @(negedge clk); bus.req_data = {8'h00, 8'h33}; #1;
        check_eq("t2_level2", 32'(bus.level),        32'h2);
        check_eq("t2_irq2",   32'(bus.irq),          32'h1);
        check_eq("t2_ready2", 32'(bus.req_ready),    32'h1);
        @(negedge clk); #1;
        check_eq("t2_level3", 32'(bus.level),        32'h3);
        check_eq("t2_full",   32'(bus.fifo_full),    32'h1);
        check_eq("t2_ready3", 32'(bus.req_ready),    32'h0);
        check_eq("t2_wen3",   32'(bus.fifo_w_en),    32'h0);
        @(negedge clk); #1;
        check_eq("t2_ready4", 32'(bus.req_ready),    32'h0);
        check_eq("t2_busy_noren", 32'(bus.fifo_r_en), 32'h0);
        bus.req_valid = '0; bus.tx_busy = 1'b0;
        wait_tx("t2_tx0", 8'h31);
        wait_tx("t2_tx1", 8'h32);
        wait_tx("t2_tx2", 8'h33);
        repeat (4) @(negedge clk);
        #1;
        check_eq("t2_level_end", 32'(bus.level),      32'h0);
        check_eq("t2_empty_end", 32'(bus.fifo_empty), 32'h1);

        // 3: single byte timing, with fifo_full blocking the first cycle.
        do_reset();
        force_full = 1'b1; bus.req_valid = 2'b10; bus.req_data = {8'h55, 8'h00}; #1;
        check_eq("t3_full_ready", 32'(bus.req_ready), 32'h0);
        check_eq("t3_full_wen",   32'(bus.fifo_w_en), 32'h0);
        @(negedge clk); force_full = 1'b0; #1;
        check_eq("t3_ready", 32'(bus.req_ready),    32'h2);
        check_eq("t3_data",  32'(bus.fifo_data_in), 32'h55);
        @(negedge clk); bus.req_valid = '0; #1;
        check_eq("t3_idle_ren", 32'(bus.fifo_r_en), 32'h0);
        check_eq("t3_level1",   32'(bus.level),     32'h1);
        check_eq("t3_gid",      32'(bus.grant_id),  32'h1);
        @(negedge clk); #1;
        check_eq("t3_pop_ren",   32'(bus.fifo_r_en), 32'h1);
        check_eq("t3_pop_start", 32'(bus.tx_start),  32'h0);
        @(negedge clk); #1;
        check_eq("t3_send_start", 32'(bus.tx_start),  32'h1);
        check_eq("t3_send_data",  32'(bus.tx_data),   32'h55);
        check_eq("t3_send_ren",   32'(bus.fifo_r_en), 32'h0);
        check_eq("t3_level0",     32'(bus.level),     32'h0);
        @(negedge clk); #1;
        check_eq("t3_hold_start", 32'(bus.tx_start), 32'h0);
        check_eq("t3_hold_data",  32'(bus.tx_data),  32'h55);

        // 4: request arriving during POP is deferred one cycle, not lost.
        do_reset();
        base_wr = n_wr; base_tx = n_txs;
        bus.req_valid = 2'b10; bus.req_data = {8'h55, 8'h00}; #1;
        check_eq("t4_ready0", 32'(bus.req_ready), 32'h2);
        @(negedge clk); bus.req_valid = '0;
        @(negedge clk); bus.req_valid = 2'b01; bus.req_data = {8'h00, 8'h66}; #1;
        check_eq("t4_pop_ready", 32'(bus.req_ready), 32'h0);
        check_eq("t4_pop_ren",   32'(bus.fifo_r_en), 32'h1);
        @(negedge clk); #1;
        check_eq("t4_ready1", 32'(bus.req_ready),    32'h1);
        check_eq("t4_data1",  32'(bus.fifo_data_in), 32'h66);
        @(negedge clk); bus.req_valid = '0; #1;
        check_eq("t4_level", 32'(bus.level),    32'h1);
        check_eq("t4_gid",   32'(bus.grant_id), 32'h0);
        wait_tx("t4_tx", 8'h66);
        repeat (6) @(negedge clk);
        #1;
        check_eq("t4_level_end", 32'(bus.level),       32'h0);
        check_eq("t4_writes",    32'(n_wr - base_wr),  32'h2);
        check_eq("t4_starts",    32'(n_txs - base_tx), 32'h2);

        // 5: set beats clear on the same cycle; clear alone clears.
        do_reset();
        bus.tx_busy = 1'b1;
        bus.req_valid = 2'b01; bus.req_data = {8'h00, 8'h11}; #1;
        check_eq("t5_ready0", 32'(bus.req_ready), 32'h1);
        @(negedge clk); bus.req_data = {8'h00, 8'h12}; bus.irq_clr = 1'b1; #1;
        check_eq("t5_ready1", 32'(bus.req_ready), 32'h1);
        check_eq("t5_level1", 32'(bus.level),     32'h1);
        @(negedge clk); bus.req_valid = '0; bus.irq_clr = 1'b0; #1;
        check_eq("t5_irq_kept", 32'(bus.irq),   32'h1);
        check_eq("t5_level2",   32'(bus.level), 32'h2);
        bus.irq_clr = 1'b1;
        @(negedge clk); bus.irq_clr = 1'b0; #1;
        check_eq("t5_irq_clr", 32'(bus.irq), 32'h0);

        // 6: reset asserted while in SEND.
        do_reset();
        bus.req_valid = 2'b11; bus.req_data = {8'h78, 8'h77};
        @(negedge clk);
        @(negedge clk); bus.req_valid = '0;
        @(negedge clk); #1;
        check_eq("t6_send_start", 32'(bus.tx_start), 32'h1);
        check_eq("t6_send_level", 32'(bus.level),    32'h1);
        check_eq("t6_send_irq",   32'(bus.irq),      32'h1);
        rst = 1'b1; #1;
        check_eq("t6_rst_start", 32'(bus.tx_start),  32'h0);
        check_eq("t6_rst_level", 32'(bus.level),     32'h0);
        check_eq("t6_rst_irq",   32'(bus.irq),       32'h0);
        check_eq("t6_rst_ren",   32'(bus.fifo_r_en), 32'h0);
        @(negedge clk); rst = 1'b0;
        base_tx = n_txs;
        repeat (5) @(negedge clk);
        #1;
        check_eq("t6_no_start", 32'(n_txs - base_tx), 32'h0);
        check_eq("t6_level",    32'(bus.level),       32'h0);

`ifdef UART_SCHED_PRIO_EN
        // Requester 0 wins every contended cycle.
        do_reset();
        bus.tx_busy = 1'b1;
        bus.req_valid = 2'b11; bus.req_data = {8'h99, 8'h88};
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("prio_ready", 32'(bus.req_ready),    32'h1);
            check_eq("prio_data",  32'(bus.fifo_data_in), 32'h88);
            @(negedge clk);
        end
        bus.req_valid = '0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_fifo_sched.md
Name: uart_fifo_sched

Overview:
Scheduler for one UART TX byte FIFO instance.
- Shares the FIFO write port between NREQ requesters with round-robin arbitration.
- Drains the FIFO into the UART transmitter with a pop/start/hold sequence.
- Tracks FIFO occupancy locally and raises a sticky watermark interrupt.
- Sits between the Wishbone-side producers (CPU MMIO, accelerator) and the FIFO/TX core in the user project.

Parameters:
- NREQ, 2, number of write requesters (2..8).
- DEPTH, 4, FIFO pointer range; usable capacity is DEPTH-1 (full = wptr+1==rptr).
- DATA_WIDTH, 8, byte width.
- IRQ_LEVEL, 2, occupancy that sets irq (1..DEPTH-1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NREQ  per-requester write valid
- req_data  in  NREQ*DATA_WIDTH  packed data; requester i at [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; transfer = valid&ready
- fifo_w_en  out  1  FIFO write enable
- fifo_data_in  out  DATA_WIDTH  granted requester's data
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- fifo_r_en  out  1  FIFO read enable
- fifo_data_out  in  DATA_WIDTH  FIFO registered read data
- tx_start  out  1  one-cycle start pulse to TX core
- tx_data  out  DATA_WIDTH  byte to transmit, valid with tx_start
- tx_busy  in  1  TX core busy; asserts within 1 cycle of tx_start
- irq_clr  in  1  clears irq
- irq  out  1  sticky watermark interrupt
- level  out  $clog2(DEPTH)  local occupancy count
- grant_id  out  $clog2(NREQ) (min 1)  index of last granted requester

Behaviour:
Reset:
- All registers reset asynchronously on rst.
- State=IDLE, rr_ptr=0, level=0, irq=0, grant_id=0.
- All enables, tx_start and req_ready are 0; tx_data=0.

Arbitration:
- Combinational. Allowed when !fifo_full, state!=POP and level<DEPTH-1.
- Search starts at rr_ptr and takes the first i with req_valid[i].
- req_ready may depend on req_valid. A requester must hold valid and data stable until ready.
- On a transfer from i: fifo_w_en=1, fifo_data_in=req_data[i], rr_ptr<=(i+1) mod NREQ, grant_id<=i.
- A non-granted requester is never starved beyond NREQ-1 transfers.

Drain FSM (IDLE, POP, SEND, HOLD):
- IDLE->POP when level!=0, !fifo_empty, !tx_busy.
- POP: fifo_r_en=1 for exactly one cycle; no write granted this cycle. Writes and pops are never simultaneous.
- POP->SEND: tx_start=1 one cycle; tx_data=fifo_data_out, registered and held until the next SEND.
- SEND->HOLD: one cycle, covering the tx_busy assertion latency.
- HOLD->IDLE.
- Minimum 4 cycles per byte.

Level:
- +1 on write, -1 on POP.
- Never wraps: write blocked at DEPTH-1, POP blocked at 0.
- If level and fifo_empty disagree, the FSM waits in IDLE.

IRQ:
- Set when a write makes level==IRQ_LEVEL.
- Cleared by irq_clr. If set and irq_clr occur in the same cycle, set wins.

Reset mid-operation:
- FSM returns to IDLE at once; any pending tx_start is dropped.
- The FIFO must be reset together with this block (integration rule).

Optional Feature:
UART_SCHED_PRIO_EN
- Defined: requester 0 has strict priority over all others. Remaining requesters use round-robin among themselves, and rr_ptr skips 0.
- Undefined: pure round-robin over all NREQ requesters.

Decomposition:
Package uart_sched_pkg:
- state enum (IDLE/POP/SEND/HOLD)
- localparams LVL_W=$clog2(DEPTH), ID_W
- function rr_pick(valid, ptr) returning index+found

Sub-module uart_rr_arb:
- Combinational pick, registered rr_ptr update.
- Instantiated once; the FSM, level and IRQ logic stay in the top.

Test Plan:
1. Reset, then req_valid=2'b11 held with data 0x41/0x42, tx_busy=0 → grants alternate 0,1,0 and fifo_data_in alternates 0x41,0x42; grant_id toggles.
2. Fill with tx_busy=1, DEPTH=4 → 3 writes accepted, level=3, then req_ready=0 while fifo_full=1; irq rises on the 2nd write (IRQ_LEVEL=2).
3. Single byte 0x55, tx_busy=0 → fifo_r_en 1 cycle later, tx_start one cycle after that with tx_data=0x55, then HOLD; level returns to 0.
4. Request arriving during POP → req_ready=0 that cycle; the request is granted the next cycle with no lost or duplicated byte.
5. irq_clr on the same cycle as the write reaching IRQ_LEVEL → irq stays 1; irq_clr alone next cycle → irq=0.
6. rst asserted in SEND → tx_start=0 immediately, state=IDLE, level=0, irq=0; with UART_SCHED_PRIO_EN, requester 0 wins every contention cycle.
